// File: rtl/simon_pkg.sv
// Shared types for the memory-game core: FSM state encoding and the LED "dark" flag.
package simon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SHOW,
        ST_GAP,
        ST_INPUT,
        ST_LOSE,
        ST_WIN
    } state_t;

    // MSB value of the LED bus that blanks every colour.
    localparam logic LED_OFF = 1'b1;

endpackage

// File: rtl/simon_seq_engine_tick_gen.sv
// Free-running divider producing a one-clk game tick every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 800000
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign o_tick = w_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/simon_seq_engine.sv
// Memory-game core: grows a random colour sequence, plays it back on the LEDs and
// checks the player's presses. All timing is in game ticks from tick_gen.
module simon_seq_engine
    import simon_pkg::*;
#(
    parameter int COLOR_W       = 2,
    parameter int MAX_LEN       = 16,
    parameter int TICK_DIV      = 800000,
    parameter int SHOW_TICKS    = 20,
    parameter int GAP_TICKS     = 5,
    parameter int TIMEOUT_TICKS = 50,
    parameter int BUZZ_TICKS    = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_start,
    input  logic [COLOR_W-1:0]           i_rnd,
    input  logic                         i_btn_valid,
    input  logic [COLOR_W-1:0]           i_btn_color,
    output logic [COLOR_W:0]             o_led,
    output logic [$clog2(MAX_LEN+1)-1:0] o_level,
    output logic [7:0]                   o_score,
    output logic                         o_buzzer,
    output logic                         o_busy,
    output logic                         o_game_over,
    output logic                         o_win,
    output state_t                       o_dbg_state
);

    localparam int LVL_W   = $clog2(MAX_LEN + 1);
    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMR_MAX = (SHOW_TICKS > GAP_TICKS) ?
                             ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS) :
                             ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int BUZ_W   = $clog2(BUZZ_TICKS + 1);

    state_t             r_state, w_next;
    logic [COLOR_W-1:0] r_seq [MAX_LEN];
    logic [LVL_W-1:0]   r_level;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_score;
    logic [TMR_W-1:0]   r_timer;
    logic [BUZ_W-1:0]   r_buzz;
    logic [COLOR_W-1:0] r_echo;
    logic               r_echo_vld;

    logic               w_tick;
    logic [COLOR_W-1:0] w_cur_color;
    logic               w_last, w_hit, w_show_done, w_gap_done, w_timeout;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // btn_valid is a single-clk strobe with btn_color valid alongside; there is no
    // back-pressure, and strobes outside INPUT are simply dropped.
    assign w_cur_color = r_seq[r_idx];
    assign w_last      = (LVL_W'(r_idx) == r_level - LVL_W'(1));
    assign w_hit       = i_btn_valid && (i_btn_color == w_cur_color);
    assign w_show_done = w_tick && (r_timer == TMR_W'(SHOW_TICKS - 1));
    assign w_gap_done  = w_tick && (r_timer == TMR_W'(GAP_TICKS - 1));
    assign w_timeout   = w_tick && (r_timer == TMR_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_LOSE, ST_WIN: if (i_start) w_next = ST_ADD;
            ST_ADD:   w_next = ST_SHOW;
            ST_SHOW:  if (w_show_done) w_next = ST_GAP;
            ST_GAP:   if (w_gap_done) w_next = w_last ? ST_INPUT : ST_SHOW;
            ST_INPUT: begin
                // A press on the same clk as the timeout tick takes priority.
                if (i_btn_valid) begin
                    if (!w_hit)      w_next = ST_LOSE;
                    else if (w_last) w_next = (r_level == LVL_W'(MAX_LEN)) ? ST_WIN : ST_ADD;
                end else if (w_timeout) begin
                    w_next = ST_LOSE;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_ADD) r_seq[r_level[IDX_W-1:0]] <= i_rnd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level    <= '0;
            r_idx      <= '0;
            r_score    <= '0;
            r_timer    <= '0;
            r_buzz     <= '0;
            r_echo     <= '0;
            r_echo_vld <= 1'b0;
        end else begin
            if (w_next != r_state || (r_state == ST_INPUT && i_btn_valid)) begin
                r_timer <= '0;
            end else if (w_tick && r_timer != TMR_W'(TMR_MAX)) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (r_state == ST_INPUT && w_next == ST_LOSE) begin
                r_buzz <= BUZ_W'(BUZZ_TICKS);
            end else if (w_next == ST_ADD && r_state != ST_INPUT) begin
                r_buzz <= '0;
            end else if (w_tick && r_buzz != '0) begin
                r_buzz <= r_buzz - BUZ_W'(1);
            end

            // Echo the pressed colour until the next tick.
            if (r_state == ST_INPUT && i_btn_valid) begin
                r_echo     <= i_btn_color;
                r_echo_vld <= 1'b1;
            end else if (w_tick || r_state != ST_INPUT) begin
                r_echo_vld <= 1'b0;
            end

            case (r_state)
                ST_IDLE, ST_LOSE, ST_WIN: begin
                    if (i_start) begin
                        r_level <= '0;
                        r_score <= '0;
                    end
                end
                ST_ADD: begin
                    r_level <= r_level + LVL_W'(1);
                    r_idx   <= '0;
                end
                ST_GAP: begin
                    if (w_gap_done) r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
                end
                ST_INPUT: begin
                    if (w_hit) begin
                        if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                        if (!w_last)          r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_led = {LED_OFF, {COLOR_W{1'b0}}};
        case (r_state)
            ST_SHOW:  o_led = {~LED_OFF, w_cur_color};
            ST_INPUT: if (r_echo_vld) o_led = {~LED_OFF, r_echo};
            default:  ;
        endcase
    end

    assign o_level     = r_level;
    assign o_score     = r_score;
    assign o_buzzer    = (r_buzz != '0);
    assign o_busy      = (r_state == ST_ADD) || (r_state == ST_SHOW) || (r_state == ST_GAP);
    assign o_game_over = (r_state == ST_LOSE);
    assign o_win       = (r_state == ST_WIN);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Directed bench for simon_seq_engine with short tick timings; expectations hand-derived.
module tb_simon_seq_engine;
    import simon_pkg::*;

    localparam int CW = 2, ML = 3, TD = 2, SH = 2, GP = 1, TO = 4, BZ = 3;

    logic          clk = 1'b0;
    logic          reset, start, btn_valid;
    logic [CW-1:0] rnd, btn_color;
    logic [CW:0]   led;
    logic [1:0]    level;
    logic [7:0]    score;
    logic          buzzer, busy, game_over, win;
    state_t        dbg;

    int n_checks = 0;
    int n_errors = 0;
    int cnt, bad;

    always #5 clk = ~clk;

    simon_seq_engine #(
        .COLOR_W(CW), .MAX_LEN(ML), .TICK_DIV(TD), .SHOW_TICKS(SH),
        .GAP_TICKS(GP), .TIMEOUT_TICKS(TO), .BUZZ_TICKS(BZ)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (start),
        .i_rnd       (rnd),
        .i_btn_valid (btn_valid),
        .i_btn_color (btn_color),
        .o_led       (led),
        .o_level     (level),
        .o_score     (score),
        .o_buzzer    (buzzer),
        .o_busy      (busy),
        .o_game_over (game_over),
        .o_win       (win),
        .o_dbg_state (dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [CW-1:0] r);
        start = 1'b1;
        rnd   = r;
        step();
        start = 1'b0;
    endtask

    task automatic press(input logic [CW-1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        step();
        btn_valid = 1'b0;
    endtask

    task automatic wait_state(input string tag, input state_t s, input int budget);
        int n;
        n = 0;
        while (dbg !== s && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(dbg), 32'(s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_color = '0; rnd = '0;
        step(3);
        reset = 1'b0;
        step();
        chk("rst_state",     32'(dbg),       32'(ST_IDLE));
        chk("rst_led",       32'(led),       32'b100);
        chk("rst_level",     32'(level),     0);
        chk("rst_score",     32'(score),     0);
        chk("rst_buzzer",    32'(buzzer),    0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_game_over", 32'(game_over), 0);
        chk("rst_win",       32'(win),       0);

        // Reset in the middle of playback.
        pulse_start(2'd1);
        wait_state("mid_show_reached", ST_SHOW, 10);
        chk("mid_show_level", 32'(level), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_state", 32'(dbg),   32'(ST_IDLE));
        chk("mid_rst_led",   32'(led),   32'b100);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_score", 32'(score), 0);
        chk("mid_rst_busy",  32'(busy),  0);

        // Game 1: three rounds played correctly -> WIN.
        pulse_start(2'd2);
        chk("g1_add_state", 32'(dbg),  32'(ST_ADD));
        chk("g1_add_busy",  32'(busy), 1);
        step();
        chk("g1_show_state", 32'(dbg),   32'(ST_SHOW));
        chk("g1_show_level", 32'(level), 1);
        chk("g1_show_led",   32'(led),   32'b010);
        cnt = 0; bad = 0;
        while (dbg === ST_SHOW && cnt < 20) begin
            if (led !== 3'b010) bad++;
            cnt++;
            step();
        end
        chk("g1_show_led_steady", 32'(bad), 0);
        chk("g1_show_len_in_range", 32'(cnt >= 2*SH*TD/2 - 1 && cnt <= 2*SH*TD/2), 1);
        chk("g1_gap_state", 32'(dbg),  32'(ST_GAP));
        chk("g1_gap_led",   32'(led),  32'b100);
        chk("g1_gap_busy",  32'(busy), 1);
        wait_state("g1_r1_input", ST_INPUT, 4);
        chk("g1_input_led",  32'(led),  32'b100);
        chk("g1_input_busy", 32'(busy), 0);
        rnd = 2'd1;
        press(2'd2);
        chk("g1_r1_add",   32'(dbg),   32'(ST_ADD));
        chk("g1_r1_score", 32'(score), 1);
        step();
        chk("g1_r2_show",  32'(dbg),   32'(ST_SHOW));
        chk("g1_r2_level", 32'(level), 2);
        wait_state("g1_r2_input", ST_INPUT, 40);
        press(2'd2);
        chk("g1_r2_mid_state", 32'(dbg),   32'(ST_INPUT));
        chk("g1_r2_mid_score", 32'(score), 2);
        chk("g1_r2_echo_led",  32'(led),   32'b010);
        press(2'd1);
        chk("g1_r2_add",   32'(dbg),   32'(ST_ADD));
        chk("g1_r2_score", 32'(score), 3);
        chk("g1_r2_level", 32'(level), 2);
        rnd = 2'd3;
        step();
        chk("g1_r3_level", 32'(level), 3);
        wait_state("g1_r3_input", ST_INPUT, 60);
        press(2'd2);
        press(2'd1);
        press(2'd3);
        chk("g1_win_state", 32'(dbg),       32'(ST_WIN));
        chk("g1_win_flag",  32'(win),       1);
        chk("g1_win_level", 32'(level),     3);
        chk("g1_win_score", 32'(score),     6);
        chk("g1_win_busy",  32'(busy),      0);
        chk("g1_win_gover", 32'(game_over), 0);
        press(2'd0);
        chk("g1_win_press_ignored", 32'(score), 6);
        chk("g1_win_hold",          32'(dbg),   32'(ST_WIN));

        // Game 2: mismatch in round 2 -> LOSE with buzzer.
        pulse_start(2'd0);
        step();
        chk("g2_level", 32'(level), 1);
        chk("g2_score", 32'(score), 0);
        chk("g2_win",   32'(win),   0);
        wait_state("g2_r1_input", ST_INPUT, 20);
        rnd = 2'd3;
        press(2'd0);
        chk("g2_r1_add", 32'(dbg), 32'(ST_ADD));
        wait_state("g2_r2_input", ST_INPUT, 40);
        press(2'd0);
        chk("g2_r2_score", 32'(score), 2);
        press(2'd2);
        chk("g2_lose_state",  32'(dbg),       32'(ST_LOSE));
        chk("g2_lose_gover",  32'(game_over), 1);
        chk("g2_lose_buzzer", 32'(buzzer),    1);
        cnt = 0;
        while (buzzer === 1'b1 && cnt < 20) begin
            cnt++;
            step();
        end
        chk("g2_buzz_len_in_range", 32'(cnt >= 2*BZ - 1 && cnt <= 2*BZ), 1);
        chk("g2_buzz_off",    32'(buzzer), 0);
        chk("g2_score_held",  32'(score),  2);
        chk("g2_still_lose",  32'(dbg),    32'(ST_LOSE));

        // Game 3: start during play ignored, then input timeout.
        pulse_start(2'd1);
        step();
        pulse_start(2'd2);
        chk("g3_start_ignored", 32'(dbg === ST_SHOW || dbg === ST_GAP), 1);
        chk("g3_level_kept",    32'(level), 1);
        wait_state("g3_input", ST_INPUT, 20);
        cnt = 0;
        while (dbg === ST_INPUT && cnt < 50) begin
            cnt++;
            step();
        end
        chk("g3_timeout_cycles", 32'(cnt),       32'(TO * TD));
        chk("g3_timeout_lose",   32'(dbg),       32'(ST_LOSE));
        chk("g3_timeout_buzzer", 32'(buzzer),    1);
        chk("g3_timeout_gover",  32'(game_over), 1);

        // Game 4: press on the same clk as the timeout tick is accepted.
        pulse_start(2'd3);
        chk("g4_buzzer_cleared", 32'(buzzer), 0);
        wait_state("g4_input", ST_INPUT, 20);
        step(TO * TD - 1);
        press(2'd3);
        chk("g4_late_press_state",  32'(dbg),       32'(ST_ADD));
        chk("g4_late_press_gover",  32'(game_over), 0);
        chk("g4_late_press_buzzer", 32'(buzzer),    0);
        chk("g4_late_press_score",  32'(score),     1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
